// File: rtl/aes_enc_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 encryption core.
// Optional zeroization is selected in aes_enc_core by the AES_ENC_ZEROIZE_EN macro.
package aes_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  localparam int ROUNDS_AES128 = 10;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_AES128);

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round numbers run 1..10; anything else yields 0 rather than an out-of-range read.
  function automatic logic [7:0] rcon_for(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h00;
    if (n >= 4'd1 && n <= LAST_ROUND) r = RCON[n - 4'd1];
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX_TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Define AES_ENC_ZEROIZE_EN to clear state and round key when leaving DONE.
module aes_enc_core
  import aes_enc_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_AES128
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AES_START,
  output logic         AES_DONE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_DEC,
  output logic [127:0] AES_MSG_ENC
);

  if (ROUNDS != ROUNDS_AES128) begin : g_bad_rounds
    $error("aes_enc_core: only ROUNDS=10 (AES-128) is supported");
  end

  aes_state_e   fsm;
  logic [127:0] state_q;
  logic [127:0] round_key;
  logic [3:0]   round_cnt;
  logic         done_q;

  logic [127:0] sub_state;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] next_key;
  logic [127:0] round_out;
  logic [31:0]  sub_word;
  logic [31:0]  key_temp;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .value(state_q[127-8*i -: 8]),
      .subst(sub_state[127-8*i -: 8])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .value(round_key[31-8*j -: 8]),
      .subst(sub_word[31-8*j -: 8])
    );
  end

  // RotWord is applied after substitution; the byte order commutes.
  assign key_temp = {sub_word[23:0], sub_word[31:24]} ^ {rcon_for(round_cnt), 24'h000000};
  assign next_key[127:96] = round_key[127:96] ^ key_temp;
  assign next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sub_state[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
  end

  assign round_out = ((round_cnt == LAST_ROUND) ? shifted : mixed) ^ next_key;

  // DONE spends its first cycle raising the flag, so the flag is always seen for a cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm       <= IDLE;
      state_q   <= '0;
      round_key <= '0;
      round_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (AES_START) begin
            state_q   <= AES_MSG_DEC ^ AES_KEY;
            round_key <= AES_KEY;
            round_cnt <= 4'd1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          state_q   <= round_out;
          round_key <= next_key;
          if (round_cnt == LAST_ROUND) fsm <= DONE;
          else round_cnt <= round_cnt + 4'd1;
        end
        DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (!AES_START) begin
            done_q <= 1'b0;
            fsm    <= IDLE;
`ifdef AES_ENC_ZEROIZE_EN
            state_q   <= '0;
            round_key <= '0;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign AES_DONE    = done_q;
  assign AES_MSG_ENC = state_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// Self-checking bench for aes_enc_core: FIPS-197 vectors, handshake corner cases and
// random vectors against a byte-level AES model. Honours AES_ENC_ZEROIZE_EN.
module tb_aes_enc_core;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_DEC;
  logic [127:0] AES_MSG_ENC;

  int checks = 0;
  int failures = 0;
  logic [7:0] sbox_ref [256];

  always #5 CLK = ~CLK;

  aes_enc_core dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .AES_START(AES_START),
    .AES_DONE(AES_DONE),
    .AES_KEY(AES_KEY),
    .AES_MSG_DEC(AES_MSG_DEC),
    .AES_MSG_ENC(AES_MSG_ENC)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           drop_at;
    int           change_at;
    int           hold;
    int           latency;
    int           width;
  } vec_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63 ^ inv;
      for (int k = 1; k <= 4; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
      sbox_ref[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_ref[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) tmp[4*c+row] = st[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          st[4*c+k] = (r == 10) ? tmp[4*c+k] :
                      gmul(tmp[4*c+k], 8'h02) ^ gmul(tmp[4*c+(k+1)%4], 8'h03) ^
                      tmp[4*c+(k+2)%4] ^ tmp[4*c+(k+3)%4];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One handshake; c counts falling edges after the start-sampling rising edge.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                               input int drop_at, input int change_at, input int hold,
                               output int latency, output int width, output logic [127:0] ct);
    @(negedge CLK);
    AES_KEY = key;
    AES_MSG_DEC = pt;
    AES_START = 1'b1;
    latency = -1;
    width = 0;
    ct = '0;
    for (int c = 0; c <= 60; c++) begin
      @(negedge CLK);
      if (c == drop_at) AES_START = 1'b0;
      if (c == change_at) begin
        AES_KEY = ~key;
        AES_MSG_DEC = ~pt;
      end
      if (AES_DONE) begin
        if (latency < 0) begin
          latency = c;
          ct = AES_MSG_ENC;
        end
        width++;
        if (AES_START && c >= latency + hold) AES_START = 1'b0;
      end else if (latency >= 0) begin
        break;
      end
    end
    AES_START = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input vec_t v);
    int lat, wid;
    logic [127:0] ct, idle_expect;
    applyStimulus(v.key, v.pt, v.drop_at, v.change_at, v.hold, lat, wid, ct);
    checkOutput({name, "_ct"}, ct, v.ct);
    checkOutput({name, "_latency"}, 128'(lat), 128'(v.latency));
    checkOutput({name, "_done_width"}, 128'(wid), 128'(v.width));
`ifdef AES_ENC_ZEROIZE_EN
    idle_expect = '0;
`else
    idle_expect = v.ct;
`endif
    checkOutput({name, "_idle_enc"}, AES_MSG_ENC, idle_expect);
  endtask

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    vec_t table_v [5];
    vec_t rv;
    logic seen;

    table_v[0] = '{KEY_A, PT_A, CT_A, -1, -1, 0, 11, 1};
    table_v[1] = '{KEY_B, PT_B, CT_B, -1, -1, 2, 11, 3};
    table_v[2] = '{KEY_A, PT_A, CT_A, 5, 3, 0, 11, 1};
    table_v[3] = '{KEY_A, PT_A, CT_A, -1, -1, 20, 11, 21};
    table_v[4] = '{KEY_A, PT_A, CT_A, -1, -1, 0, 11, 1};

    buildSbox();

    RESET_N = 1'b0;
    AES_START = 1'b0;
    AES_KEY = '0;
    AES_MSG_DEC = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_done", 128'(AES_DONE), 128'(0));
    checkOutput("reset_enc", AES_MSG_ENC, '0);
    RESET_N = 1'b1;

    for (int i = 0; i < 5; i++) runAndCheck($sformatf("vec%0d", i), table_v[i]);

    // Reset in the middle of the rounds.
    @(negedge CLK);
    AES_KEY = KEY_B;
    AES_MSG_DEC = PT_B;
    AES_START = 1'b1;
    repeat (7) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    checkOutput("midround_reset_enc", AES_MSG_ENC, '0);
    checkOutput("midround_reset_done", 128'(AES_DONE), 128'(0));
    @(negedge CLK);
    AES_START = 1'b0;
    RESET_N = 1'b1;
    runAndCheck("after_reset", table_v[0]);

    // Reset while DONE is being held.
    @(negedge CLK);
    AES_KEY = KEY_A;
    AES_MSG_DEC = PT_A;
    AES_START = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      seen = AES_DONE;
    end
    checkOutput("done_before_reset", 128'(seen), 128'(1));
    RESET_N = 1'b0;
    #1;
    checkOutput("done_reset_done", 128'(AES_DONE), 128'(0));
    checkOutput("done_reset_enc", AES_MSG_ENC, '0);
    @(negedge CLK);
    AES_START = 1'b0;
    RESET_N = 1'b1;

    for (int i = 0; i < 6; i++) begin
      rv.key = {$urandom, $urandom, $urandom, $urandom};
      rv.pt = {$urandom, $urandom, $urandom, $urandom};
      rv.ct = aes_ref(rv.key, rv.pt);
      rv.drop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
      rv.change_at = int'($urandom_range(0, 10));
      rv.hold = (rv.drop_at >= 0) ? 0 : int'($urandom_range(0, 3));
      rv.latency = 11;
      rv.width = rv.hold + 1;
      runAndCheck($sformatf("rand%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 Parameter: ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal, elaboration SHALL fail otherwise.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: AES_START  input  1  request; level-held by host until AES_DONE seen.
REQ-005 Port: AES_DONE  output  1  result valid; held until AES_START low.
REQ-006 Port: AES_KEY  input  128  cipher key; bits [127:120] = key byte 0.
REQ-007 Port: AES_MSG_DEC  input  128  plaintext; bits [127:120] = state byte 0, column-major per FIPS-197.
REQ-008 Port: AES_MSG_ENC  output  128  ciphertext, same byte order.

Function
REQ-009 FSM states SHALL be IDLE, ROUND, DONE.
REQ-010 IDLE: on AES_START=1, SHALL register state <= AES_MSG_DEC ^ AES_KEY, round key <= AES_KEY, round counter <= 1, then go to ROUND.
REQ-011 AES_KEY and AES_MSG_DEC SHALL be sampled only on the IDLE->ROUND edge; later changes are ignored.
REQ-012 ROUND, each cycle: next round key = on-the-fly expansion of current round key with RCON[counter]; state <= MixColumns(ShiftRows(SubBytes(state))) ^ next key; round key <= next key; counter +1.
REQ-013 When counter = 10, MixColumns SHALL be bypassed and the next state SHALL be DONE.
REQ-014 Latency: AES_DONE SHALL assert exactly 11 cycles after the edge where AES_START is sampled high in IDLE.
REQ-015 DONE: AES_DONE=1 and AES_MSG_ENC = final state; exit to IDLE on first cycle with AES_START=0. DONE lasts at least 1 cycle.
REQ-016 AES_START deasserted during ROUND SHALL NOT abort; the operation completes, and DONE then lasts exactly 1 cycle.
REQ-017 AES_START held high through DONE SHALL NOT start a new operation; a new start requires a return to IDLE.
REQ-018 AES_MSG_ENC SHALL be driven directly from the state register, with no combinational path from inputs.
REQ-019 RCON SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10. The 4-bit counter SHALL never exceed 10.

Reset
REQ-020 RESET_N=0 SHALL immediately force IDLE, AES_DONE=0, AES_MSG_ENC=0, round key=0, counter=0, including mid-ROUND.
REQ-021 After RESET_N rises, the first AES_START=1 SHALL begin a fresh operation per REQ-010.

Configuration
REQ-022 Macro AES_ENC_ZEROIZE_EN: when defined, the state and round-key registers SHALL clear to 0 on the DONE->IDLE transition, so AES_MSG_ENC reads 0 outside DONE.
REQ-023 Without AES_ENC_ZEROIZE_EN, AES_MSG_ENC SHALL hold the last ciphertext in IDLE until the next start.

Structure
REQ-024 Package aes_enc_pkg SHALL hold the FSM state enum, the RCON table, ROUNDS_AES128=10 and the GF(2^8) xtime function.
REQ-025 Sub-module aes_sbox (combinational, 8-bit forward S-box) SHALL be instantiated 20 times: 16 for the state and 4 for the key schedule.
REQ-026 ShiftRows, MixColumns and key expansion SHALL be combinational logic inside aes_enc_core, with no additional clocked elements.

Verification
REQ-027 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> AES_MSG_ENC 69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE at cycle 11.
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> AES_MSG_ENC 3925841d02dc09fbdc118597196a0b32.
REQ-029 Drop AES_START at cycle 5 and change AES_KEY at cycle 3 -> correct REQ-027 result, AES_DONE high for exactly 1 cycle.
REQ-030 Hold AES_START high for 20 cycles after AES_DONE -> no restart; on deassert -> IDLE, then a restart gives the same result.
REQ-031 RESET_N low at cycle 6 -> AES_DONE=0 and AES_MSG_ENC=0 immediately; the next run gives the correct result.
REQ-032 With and without AES_ENC_ZEROIZE_EN, sample AES_MSG_ENC in IDLE after a run -> 0 with the macro, last ciphertext without it.
